// File: rtl/ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_cmd_arbiter
//  Description : Round-robin arbiter that merges per-bank FSM command
//                requests and the refresh FSM request onto one registered
//                DDR3 command bus. Refresh has absolute priority. ACTIVATE
//                spacing (tRRD) and column spacing (tCCD) are enforced.
//                Bank command type encoding, 3 bits per bank:
//                  0 NOP, 1 ACTIVATE, 2 READ, 3 WRITE, 4 PRECHARGE, 5 REFRESH
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_cmd_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 13,
    parameter int BA_W      = $clog2(NUM_BANKS),
    parameter int T_RRD     = 2,
    parameter int T_CCD     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_BANKS-1:0]          bank_cmd_valid,
    input  logic [NUM_BANKS*3-1:0]        bank_cmd_type,
    input  logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
    output logic [NUM_BANKS-1:0]          bank_cmd_ready,
    input  logic                          refresh_cmd_valid,
    output logic                          refresh_cmd_ready,
    output logic                          ddr3_ras_n,
    output logic                          ddr3_cas_n,
    output logic                          ddr3_we_n,
    output logic [BA_W-1:0]               ddr3_ba,
    output logic [ADDR_W-1:0]             ddr3_addr
);

    localparam logic [2:0] c_cmd_nop = 3'd0;
    localparam logic [2:0] c_cmd_act = 3'd1;
    localparam logic [2:0] c_cmd_rd  = 3'd2;
    localparam logic [2:0] c_cmd_wr  = 3'd3;
    localparam logic [2:0] c_cmd_pre = 3'd4;
    localparam logic [2:0] c_cmd_ref = 3'd5;

    // {ras_n, cas_n, we_n} pin patterns
    localparam logic [2:0] c_pin_nop = 3'b111;
    localparam logic [2:0] c_pin_act = 3'b011;
    localparam logic [2:0] c_pin_rd  = 3'b101;
    localparam logic [2:0] c_pin_wr  = 3'b100;
    localparam logic [2:0] c_pin_pre = 3'b010;
    localparam logic [2:0] c_pin_ref = 3'b001;

    // Counters only need to hold T-1
    localparam int RRD_W = (T_RRD > 1) ? $clog2(T_RRD) : 1;
    localparam int CCD_W = (T_CCD > 1) ? $clog2(T_CCD) : 1;

    logic [BA_W-1:0]   prio_ptr_q, prio_ptr_d;
    logic [RRD_W-1:0]  rrd_cnt_q,  rrd_cnt_d;
    logic [CCD_W-1:0]  ccd_cnt_q,  ccd_cnt_d;
    logic [2:0]        pins_q,     pins_d;
    logic [BA_W-1:0]   ba_q,       ba_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;

    logic [2:0]        w_type [NUM_BANKS];
    logic [ADDR_W-1:0] w_addr [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_elig;
    logic              w_grant_any;
    logic [BA_W-1:0]   w_grant_idx;
    logic [BA_W-1:0]   w_scan_idx;
    logic [2:0]        w_grant_type;

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            assign w_type[g] = bank_cmd_type[g*3 +: 3];
            assign w_addr[g] = bank_addr[g*ADDR_W +: ADDR_W];

            // Per-bank eligibility from command type and spacing counters
            always_comb begin
                w_elig[g] = 1'b0;
                case (w_type[g])
                    c_cmd_act: w_elig[g] = (rrd_cnt_q == '0);
                    c_cmd_rd,
                    c_cmd_wr:  w_elig[g] = (ccd_cnt_q == '0);
                    c_cmd_pre,
                    c_cmd_nop: w_elig[g] = 1'b1;
                    default:   w_elig[g] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Round-robin scan from prio_ptr; blocked banks are skipped, refresh wins
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_scan_idx = prio_ptr_q + BA_W'(i);
            if (!w_grant_any && bank_cmd_valid[w_scan_idx] && w_elig[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        if (!rst_n || refresh_cmd_valid) begin
            w_grant_any = 1'b0;
        end
    end

    assign w_grant_type = w_type[w_grant_idx];

    // Handshake readies: onehot0 across banks and refresh
    always_comb begin
        bank_cmd_ready = '0;
        if (w_grant_any) begin
            bank_cmd_ready[w_grant_idx] = 1'b1;
        end
        refresh_cmd_ready = rst_n & refresh_cmd_valid;
    end

    // Priority pointer advance and spacing counter reload/decrement
    always_comb begin
        prio_ptr_d = prio_ptr_q;
        rrd_cnt_d  = (rrd_cnt_q != '0) ? rrd_cnt_q - 1'b1 : '0;
        ccd_cnt_d  = (ccd_cnt_q != '0) ? ccd_cnt_q - 1'b1 : '0;
        if (w_grant_any) begin
            prio_ptr_d = w_grant_idx + 1'b1;
            if (w_grant_type == c_cmd_act) begin
                rrd_cnt_d = RRD_W'(T_RRD - 1);
            end
            if (w_grant_type == c_cmd_rd || w_grant_type == c_cmd_wr) begin
                ccd_cnt_d = CCD_W'(T_CCD - 1);
            end
        end
    end

    // Next pin values: NOP unless something is granted this cycle
    always_comb begin
        pins_d = c_pin_nop;
        ba_d   = '0;
        addr_d = '0;
        if (refresh_cmd_ready) begin
            pins_d = c_pin_ref;
        end else if (w_grant_any) begin
            ba_d   = w_grant_idx;
            addr_d = w_addr[w_grant_idx];
            case (w_grant_type)
                c_cmd_act: pins_d = c_pin_act;
                c_cmd_rd:  pins_d = c_pin_rd;
                c_cmd_wr:  pins_d = c_pin_wr;
                c_cmd_pre: pins_d = c_pin_pre;
                default:   pins_d = c_pin_nop;
            endcase
        end
    end

    // State and registered command pins; reset drops any pending command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_ptr_q <= '0;
            rrd_cnt_q  <= '0;
            ccd_cnt_q  <= '0;
            pins_q     <= c_pin_nop;
            ba_q       <= '0;
            addr_q     <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
            rrd_cnt_q  <= rrd_cnt_d;
            ccd_cnt_q  <= ccd_cnt_d;
            pins_q     <= pins_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
        end
    end

    assign ddr3_ras_n = pins_q[2];
    assign ddr3_cas_n = pins_q[1];
    assign ddr3_we_n  = pins_q[0];
    assign ddr3_ba    = ba_q;
    assign ddr3_addr  = addr_q;

`ifndef SYNTHESIS
    // REFRESH may only come from the refresh FSM, never from a bank requester
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                assert (!(bank_cmd_valid[i] && (w_type[i] == c_cmd_ref)));
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_cmd_arbiter
//  Description : Self-checking bench for ddr3_cmd_arbiter. A 4-bank instance
//                (T_RRD=4, T_CCD=4) and an 8-bank instance are driven from
//                shared stimulus, selected by r_sel. Expected pins are queued
//                when stimulus is applied and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_arbiter;

    localparam logic [2:0] c_nop = 3'd0;
    localparam logic [2:0] c_act = 3'd1;
    localparam logic [2:0] c_rd  = 3'd2;
    localparam logic [2:0] c_wr  = 3'd3;
    localparam logic [2:0] c_pre = 3'd4;
    localparam logic [2:0] c_ref = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        r_sel;
    logic        r_rvalid;
    logic [7:0]  r_valid;
    logic [2:0]  r_type [8];
    logic [12:0] r_addr [8];

    logic [23:0]  w_type_flat;
    logic [103:0] w_addr_flat;

    always_comb begin
        w_type_flat = '0;
        w_addr_flat = '0;
        for (int i = 0; i < 8; i++) begin
            w_type_flat[i*3 +: 3]   = r_type[i];
            w_addr_flat[i*13 +: 13] = r_addr[i];
        end
    end

    // 4-bank instance
    logic [3:0]  w_rdy4;
    logic        w_rr4, w_ras4, w_cas4, w_we4;
    logic [1:0]  w_ba4;
    logic [12:0] w_a4;

    ddr3_cmd_arbiter #(.NUM_BANKS(4), .ADDR_W(13), .T_RRD(4), .T_CCD(4)) dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .bank_cmd_valid    (r_sel ? 4'b0 : r_valid[3:0]),
        .bank_cmd_type     (w_type_flat[11:0]),
        .bank_addr         (w_addr_flat[51:0]),
        .bank_cmd_ready    (w_rdy4),
        .refresh_cmd_valid (r_rvalid & ~r_sel),
        .refresh_cmd_ready (w_rr4),
        .ddr3_ras_n        (w_ras4),
        .ddr3_cas_n        (w_cas4),
        .ddr3_we_n         (w_we4),
        .ddr3_ba           (w_ba4),
        .ddr3_addr         (w_a4)
    );

    // 8-bank instance
    logic [7:0]  w_rdy8;
    logic        w_rr8, w_ras8, w_cas8, w_we8;
    logic [2:0]  w_ba8;
    logic [12:0] w_a8;

    ddr3_cmd_arbiter #(.NUM_BANKS(8), .ADDR_W(13)) dut8 (
        .clk               (clk),
        .rst_n             (rst_n),
        .bank_cmd_valid    (r_sel ? r_valid : 8'b0),
        .bank_cmd_type     (w_type_flat),
        .bank_addr         (w_addr_flat),
        .bank_cmd_ready    (w_rdy8),
        .refresh_cmd_valid (r_rvalid & r_sel),
        .refresh_cmd_ready (w_rr8),
        .ddr3_ras_n        (w_ras8),
        .ddr3_cas_n        (w_cas8),
        .ddr3_we_n         (w_we8),
        .ddr3_ba           (w_ba8),
        .ddr3_addr         (w_a8)
    );

    logic [7:0]  w_obs_rdy;
    logic        w_obs_rr;
    logic [18:0] w_obs_pins;

    assign w_obs_rdy  = r_sel ? w_rdy8 : {4'b0, w_rdy4};
    assign w_obs_rr   = r_sel ? w_rr8  : w_rr4;
    assign w_obs_pins = r_sel ? {w_ras8, w_cas8, w_we8, w_ba8, w_a8}
                              : {w_ras4, w_cas4, w_we4, 1'b0, w_ba4, w_a4};

    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] sb [$];

    // Expected pin word {ras_n,cas_n,we_n,ba[2:0],addr[12:0]}
    function automatic logic [18:0] pinw(input logic [2:0] cmd, input int ba, input int addr);
        logic [2:0] p;
        case (cmd)
            c_act:   p = 3'b011;
            c_rd:    p = 3'b101;
            c_wr:    p = 3'b100;
            c_pre:   p = 3'b010;
            c_ref:   p = 3'b001;
            default: p = 3'b111;
        endcase
        return {p, 3'(ba), 13'(addr)};
    endfunction

    localparam logic [18:0] c_nop_pins = {3'b111, 16'h0};

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare pins from last cycle's grant, check readies,
    // queue the pins this cycle's grant must produce
    task automatic step(input string tag, input logic [7:0] erdy, input logic eref,
                        input logic [18:0] enext);
        logic [18:0] e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val({tag, "/pins"}, 32'(w_obs_pins), 32'(e));
        end
        chk_val({tag, "/rdy"}, 32'(w_obs_rdy), 32'(erdy));
        chk_val({tag, "/ref_rdy"}, 32'(w_obs_rr), 32'(eref));
        sb.push_back(enext);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r_valid  = '0;
        r_rvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_type[i] = c_nop;
            r_addr[i] = '0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        step("rst0", 8'h0, 1'b0, c_nop_pins);
        step("rst1", 8'h0, 1'b0, c_nop_pins);
        rst_n = 1'b1;
    endtask

    // All banks hold PRECHARGE; optional one-cycle reset at cycle rst_at
    task automatic rr_pre(input int nb, input int ncyc, input int rst_at);
        int g;
        g = 0;
        for (int i = 0; i < nb; i++) begin
            r_valid[i] = 1'b1;
            r_type[i]  = c_pre;
            r_addr[i]  = 13'h400 | 13'(i);
        end
        for (int c = 0; c < ncyc; c++) begin
            if (c == rst_at) begin
                rst_n = 1'b0;
                step($sformatf("rr%0d_rst", nb), 8'h0, 1'b0, c_nop_pins);
                rst_n = 1'b1;
                g = 0;
            end else begin
                step($sformatf("rr%0d_c%0d", nb, c), 8'(1 << g), 1'b0,
                     pinw(c_pre, g, 'h400 | g));
                g = (g + 1) % nb;
            end
        end
        r_valid = '0;
        step("rr_idle", 8'h0, 1'b0, c_nop_pins);
    endtask

    initial begin
        rst_n = 1'b0;
        r_sel = 1'b0;
        clear_inputs();
        apply_reset();

        // 1: single ACTIVATE, one-cycle latency, NOP afterwards
        r_valid[0] = 1'b1; r_type[0] = c_act; r_addr[0] = 13'h100;
        step("t1_grant", 8'h01, 1'b0, pinw(c_act, 0, 'h100));
        r_valid[0] = 1'b0;
        step("t1_issue", 8'h00, 1'b0, c_nop_pins);
        step("t1_after", 8'h00, 1'b0, c_nop_pins);

        // 2: round-robin over held PRECHARGE requests
        apply_reset();
        rr_pre(4, 5, -1);

        // 3: tRRD=4 spacing between ACTIVATEs
        apply_reset();
        r_valid[1:0] = 2'b11;
        r_type[0] = c_act; r_addr[0] = 13'h010;
        r_type[1] = c_act; r_addr[1] = 13'h011;
        step("t3_act0", 8'h01, 1'b0, pinw(c_act, 0, 'h010));
        r_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("t3_wait%0d", i), 8'h00, 1'b0, c_nop_pins);
        end
        step("t3_act1", 8'h02, 1'b0, pinw(c_act, 1, 'h011));
        r_valid[1] = 1'b0;
        step("t3_idle", 8'h00, 1'b0, c_nop_pins);

        // 4: refresh beats bank requests; pointer not moved by REF
        apply_reset();
        r_rvalid = 1'b1;
        r_valid[2] = 1'b1; r_type[2] = c_rd;  r_addr[2] = 13'h022;
        r_valid[3] = 1'b1; r_type[3] = c_pre; r_addr[3] = 13'h400;
        step("t4_ref", 8'h00, 1'b1, pinw(c_ref, 0, 0));
        r_rvalid = 1'b0;
        step("t4_rd2", 8'h04, 1'b0, pinw(c_rd, 2, 'h022));
        r_valid[2] = 1'b0;
        step("t4_pre3", 8'h08, 1'b0, pinw(c_pre, 3, 'h400));
        r_valid[3] = 1'b0;
        step("t4_idle", 8'h00, 1'b0, c_nop_pins);

        // 5: tCCD=4 gap filled by a PRECHARGE
        apply_reset();
        r_valid[1] = 1'b1; r_type[1] = c_rd; r_addr[1] = 13'h031;
        step("t5_rd1", 8'h02, 1'b0, pinw(c_rd, 1, 'h031));
        r_valid[1] = 1'b0;
        r_valid[3] = 1'b1; r_type[3] = c_wr;  r_addr[3] = 13'h033;
        r_valid[0] = 1'b1; r_type[0] = c_pre; r_addr[0] = 13'h000;
        step("t5_pre0", 8'h01, 1'b0, pinw(c_pre, 0, 0));
        r_valid[0] = 1'b0;
        step("t5_wait0", 8'h00, 1'b0, c_nop_pins);
        step("t5_wait1", 8'h00, 1'b0, c_nop_pins);
        step("t5_wr3", 8'h08, 1'b0, pinw(c_wr, 3, 'h033));
        r_valid[3] = 1'b0;
        step("t5_idle", 8'h00, 1'b0, c_nop_pins);

        // 6: reset mid-stream restarts at bank 0, for 4 and 8 banks
        apply_reset();
        rr_pre(4, 6, 2);
        r_sel = 1'b1;
        apply_reset();
        rr_pre(8, 12, 3);

        // 7: lone requester at the top bank wraps and is granted every cycle
        r_sel = 1'b0;
        apply_reset();
        r_valid[3] = 1'b1; r_type[3] = c_pre; r_addr[3] = 13'h403;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("t7_lone%0d", i), 8'h08, 1'b0, pinw(c_pre, 3, 'h403));
        end
        r_valid[3] = 1'b0;
        step("t7_idle", 8'h00, 1'b0, c_nop_pins);
        step("t7_drain", 8'h00, 1'b0, c_nop_pins);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
